// File: rtl/pfd_stim_gen.sv
// rtl/pfd_stim_gen.sv - two-phase burst stimulus generator for the PLL phase-frequency detector
module pfd_stim_gen #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stop,
    input  logic [CNT_W-1:0] Half_period,
    input  logic [CNT_W-1:0] Offset,
    input  logic             Lead_b,
    input  logic [NUM_W-1:0] Num_edges,
    output logic             A,
    output logic             B,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] lag_q, lag_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [NUM_W-1:0] lead_cnt_q, lead_cnt_d;
    logic [NUM_W-1:0] lag_cnt_q, lag_cnt_d;
    logic             lead_b_q, lead_b_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] half_eff;
    logic [CNT_W-1:0] phase_nxt;
    logic [NUM_W-1:0] lead_cnt_nxt;
    logic [NUM_W-1:0] lag_cnt_nxt;
    logic             lead_tog;
    logic             lag_tog;

    always_comb begin
        half_eff  = (Half_period == '0) ? CNT_W'(1) : Half_period;
        // phase_nxt is the elapsed cycle count since Start, modulo the half-period
        phase_nxt = (phase_q == half_q - CNT_W'(1)) ? '0 : phase_q + CNT_W'(1);
        lead_tog  = (phase_nxt == '0) && (lead_cnt_q < num_q);
        lead_cnt_nxt = lead_cnt_q + NUM_W'(lead_tog);
        // lag edge k may only follow lead edge k; this also covers a zero lag
        lag_tog   = (phase_nxt == lag_q) && (lag_cnt_q < lead_cnt_nxt);
        lag_cnt_nxt = lag_cnt_q + NUM_W'(lag_tog);

        state_d    = state_q;
        half_d     = half_q;
        lag_d      = lag_q;
        phase_d    = phase_q;
        num_d      = num_q;
        lead_cnt_d = lead_cnt_q;
        lag_cnt_d  = lag_cnt_q;
        lead_b_d   = lead_b_q;
        a_d        = a_q;
        b_d        = b_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d    = S_RUN;
                    half_d     = half_eff;
                    lag_d      = (Offset > half_eff - CNT_W'(1)) ? half_eff - CNT_W'(1) : Offset;
                    num_d      = Num_edges;
                    lead_b_d   = Lead_b;
                    phase_d    = '0;
                    lead_cnt_d = '0;
                    lag_cnt_d  = '0;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                end
            end
            S_RUN: begin
                if (Stop) begin
                    state_d = S_IDLE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end else begin
                    phase_d    = phase_nxt;
                    lead_cnt_d = lead_cnt_nxt;
                    lag_cnt_d  = lag_cnt_nxt;
                    a_d        = a_q ^ (lead_b_q ? lag_tog : lead_tog);
                    b_d        = b_q ^ (lead_b_q ? lead_tog : lag_tog);
                    if (lag_cnt_nxt == num_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            half_q     <= CNT_W'(1);
            lag_q      <= '0;
            phase_q    <= '0;
            num_q      <= '0;
            lead_cnt_q <= '0;
            lag_cnt_q  <= '0;
            lead_b_q   <= 1'b0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            lag_q      <= lag_d;
            phase_q    <= phase_d;
            num_q      <= num_d;
            lead_cnt_q <= lead_cnt_d;
            lag_cnt_q  <= lag_cnt_d;
            lead_b_q   <= lead_b_d;
            a_q        <= a_d;
            b_q        <= b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign A    = a_q;
    assign B    = b_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_pfd_stim_gen.sv
// tb/tb_pfd_stim_gen.sv - self-checking bench for pfd_stim_gen against an arithmetic burst model
module tb_pfd_stim_gen;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Stop;
    logic [7:0] Half_period;
    logic [7:0] Offset;
    logic       Lead_b;
    logic [7:0] Num_edges;
    logic       A;
    logic       B;
    logic       Busy;
    logic       Done;

    int tests = 0;
    int fails = 0;

    int   cyc  = 0;
    logic m_run = 1'b0;
    int   m_t0 = 0;
    int   m_h  = 1;
    int   m_d  = 0;
    int   m_n  = 0;
    logic m_lb = 1'b0;
    logic m_a  = 1'b0;
    logic m_b  = 1'b0;
    logic m_done = 1'b0;

    pfd_stim_gen #(.CNT_W(8), .NUM_W(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Stop       (Stop),
        .Half_period(Half_period),
        .Offset     (Offset),
        .Lead_b     (Lead_b),
        .Num_edges  (Num_edges),
        .A          (A),
        .B          (B),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d e=%0d got=%b expected=%b", nm, cyc, cyc - m_t0, act, exp);
        end
    endtask

    // Burst outputs as a closed-form function of elapsed cycles since Start.
    task automatic model_edge();
        int e;
        int t;
        int lc;
        int gc;
        cyc++;
        if (m_run) begin
            e = cyc - m_t0;
            if (Stop) begin
                m_run  = 1'b0;
                m_a    = 1'b0;
                m_b    = 1'b0;
                m_done = 1'b0;
            end else begin
                t  = (m_n == 0) ? 1 : m_n * m_h + m_d;
                lc = imin(m_n, e / m_h);
                gc = (e < m_d) ? 0 : imin(m_n, (e - m_d) / m_h);
                m_a    = m_lb ? gc[0] : lc[0];
                m_b    = m_lb ? lc[0] : gc[0];
                m_done = (e == t);
                m_run  = (e < t);
            end
        end else begin
            m_done = 1'b0;
            if (Start) begin
                m_run = 1'b1;
                m_t0  = cyc;
                m_h   = (Half_period == 8'd0) ? 1 : int'(Half_period);
                m_d   = imin(int'(Offset), m_h - 1);
                m_n   = int'(Num_edges);
                m_lb  = Lead_b;
                m_a   = 1'b0;
                m_b   = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        chk("A", A, m_a);
        chk("B", B, m_b);
        chk("Busy", Busy, m_run);
        chk("Done", Done, m_done);
    endtask

    task automatic start_burst(input logic [7:0] h, input logic [7:0] o, input logic lb, input logic [7:0] n);
        Half_period = h;
        Offset      = o;
        Lead_b      = lb;
        Num_edges   = n;
        Start       = 1'b1;
        step();
        Start       = 1'b0;
    endtask

    task automatic run_to(input int e);
        int g;
        g = 0;
        while ((cyc - m_t0) < e && g < 1000) begin
            step();
            g++;
        end
        if ((cyc - m_t0) != e) begin
            tests++;
            fails++;
            $display("FAIL run_to target=%0d reached=%0d", e, cyc - m_t0);
        end
    endtask

    initial begin
        Reset       = 1'b1;
        Start       = 1'b0;
        Stop        = 1'b0;
        Half_period = 8'd0;
        Offset      = 8'd0;
        Lead_b      = 1'b0;
        Num_edges   = 8'd0;
        #1;
        chk("rst_A", A, 1'b0);
        chk("rst_B", B, 1'b0);
        chk("rst_Busy", Busy, 1'b0);
        chk("rst_Done", Done, 1'b0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        step();

        // 1: A leads, H=5, D=2, N=4
        start_burst(8'd5, 8'd2, 1'b0, 8'd4);
        chk("s1_busy_t0", Busy, 1'b1);
        run_to(4);  chk("s1_a_e4", A, 1'b0);
        run_to(5);  chk("s1_a_e5", A, 1'b1);
        run_to(6);  chk("s1_b_e6", B, 1'b0);
        run_to(7);  chk("s1_b_e7", B, 1'b1);
        run_to(21); chk("s1_busy_e21", Busy, 1'b1);
        run_to(22);
        chk("s1_done_e22", Done, 1'b1);
        chk("s1_busy_e22", Busy, 1'b0);
        chk("s1_a_final", A, 1'b0);
        chk("s1_b_final", B, 1'b0);
        run_to(23); chk("s1_done_e23", Done, 1'b0);

        // 2: B leads, N=3
        start_burst(8'd5, 8'd2, 1'b1, 8'd3);
        run_to(5);  chk("s2_b_e5", B, 1'b1); chk("s2_a_e5", A, 1'b0);
        run_to(7);  chk("s2_a_e7", A, 1'b1);
        run_to(17);
        chk("s2_done_e17", Done, 1'b1);
        chk("s2_a_final", A, 1'b1);
        chk("s2_b_final", B, 1'b1);
        repeat (3) step();
        chk("s2_a_hold", A, 1'b1);

        // 3: offset clamp, zero lag, zero edges
        start_burst(8'd4, 8'd9, 1'b0, 8'd2);
        run_to(7);  chk("s3a_b_e7", B, 1'b1);
        run_to(8);  chk("s3a_a_e8", A, 1'b0);
        run_to(11); chk("s3a_done_e11", Done, 1'b1); chk("s3a_b_e11", B, 1'b0);
        start_burst(8'd3, 8'd0, 1'b0, 8'd2);
        run_to(3);  chk("s3b_a_e3", A, 1'b1); chk("s3b_b_e3", B, 1'b1);
        run_to(6);  chk("s3b_done_e6", Done, 1'b1);
        step();
        start_burst(8'd7, 8'd3, 1'b0, 8'd0);
        run_to(1);  chk("s3c_done_e1", Done, 1'b1); chk("s3c_busy_e1", Busy, 1'b0); chk("s3c_a", A, 1'b0);
        step();

        // 4: ignored Start mid-burst, then Stop
        start_burst(8'd6, 8'd1, 1'b0, 8'd10);
        run_to(7);
        Start = 1'b1;
        Half_period = 8'd2;
        step();
        Start = 1'b0;
        run_to(19); chk("s4_a_e19", A, 1'b1); chk("s4_b_e19", B, 1'b1);
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        chk("s4_a_stop", A, 1'b0);
        chk("s4_b_stop", B, 1'b0);
        chk("s4_busy_stop", Busy, 1'b0);
        chk("s4_done_stop", Done, 1'b0);
        step();
        chk("s4_done_after", Done, 1'b0);

        // 5: asynchronous reset mid-burst
        start_burst(8'd5, 8'd2, 1'b0, 8'd4);
        run_to(6);  chk("s5_a_pre", A, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        chk("s5_a_rst", A, 1'b0);
        chk("s5_b_rst", B, 1'b0);
        chk("s5_busy_rst", Busy, 1'b0);
        m_run = 1'b0; m_a = 1'b0; m_b = 1'b0; m_done = 1'b0;
        @(posedge Clk);
        #1;
        chk("s5_done_rst", Done, 1'b0);
        Reset = 1'b0;
        step();
        start_burst(8'd5, 8'd2, 1'b0, 8'd4);
        run_to(5);  chk("s5_a_e5", A, 1'b1);
        run_to(22); chk("s5_done_e22", Done, 1'b1);

        // 6: back-to-back with H=0
        start_burst(8'd3, 8'd1, 1'b0, 8'd3);
        run_to(10);
        chk("s6_done_e10", Done, 1'b1);
        chk("s6_a_final", A, 1'b1);
        start_burst(8'd0, 8'd3, 1'b0, 8'd5);
        chk("s6_a_clr", A, 1'b0);
        chk("s6_b_clr", B, 1'b0);
        chk("s6_busy", Busy, 1'b1);
        run_to(1);  chk("s6_a_e1", A, 1'b1); chk("s6_b_e1", B, 1'b1);
        run_to(2);  chk("s6_a_e2", A, 1'b0);
        run_to(5);  chk("s6_done_e5", Done, 1'b1);

        // Stop and Start together while idle
        Stop = 1'b1;
        start_burst(8'd2, 8'd0, 1'b1, 8'd1);
        Stop = 1'b0;
        chk("ss_busy", Busy, 1'b1);
        run_to(2);  chk("ss_done", Done, 1'b1);

        // Randomized bursts with input noise during the run
        for (int r = 0; r < 40; r++) begin
            int g;
            logic [7:0] h;
            h = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(10, 40)) : 8'($urandom_range(0, 9));
            start_burst(h, 8'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 6)));
            g = 0;
            while (m_run && g < 400) begin
                Start       = ($urandom_range(0, 9) == 0);
                Stop        = ($urandom_range(0, 99) == 0);
                Half_period = 8'($urandom_range(0, 255));
                Offset      = 8'($urandom_range(0, 255));
                Lead_b      = 1'($urandom_range(0, 1));
                Num_edges   = 8'($urandom_range(0, 255));
                step();
                g++;
            end
            Start = 1'b0;
            Stop  = 1'b0;
            if (m_run) begin
                tests++;
                fails++;
                $display("FAIL rand_burst_bound r=%0d", r);
            end
            Stop = ($urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) step();
            Stop = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pfd_stim_gen.md
Name: pfd_stim_gen

Overview:
- Programmable two-phase clock generator that drives the A/B inputs of the PLL phase-frequency detector.
- Produces two square waves with the same half-period and a programmable lag, with either A or B leading.
- Runs a finite burst of edges from one system clock, so PFD lead/lag response is exercised on-chip and in simulation without hand-written stimulus.

Parameters:
CNT_W, 8, width of half-period and offset fields (cycles)
NUM_W, 8, width of edge-count field

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  single-cycle request; accepted only when idle
Stop  input  1  synchronous abort of a running burst
Half_period  input  CNT_W  cycles between successive toggles of each output; 0 treated as 1
Offset  input  CNT_W  lag in cycles of the lagging output behind the leading one
Lead_b  input  1  0: A leads, B lags; 1: B leads, A lags
Num_edges  input  NUM_W  number of toggles per output in the burst
A  output  1  PFD reference-side stimulus (registered)
B  output  1  PFD feedback-side stimulus (registered)
Busy  output  1  high while a burst is running
Done  output  1  one-cycle pulse at burst completion

Behaviour:
- Clock and reset: one clock, Clk; reset is asynchronous and active-high, port Reset.
- Reset values: A=0, B=0, Busy=0, Done=0, FSM in IDLE. Reset asserted mid-burst aborts immediately; no Done pulse.
- FSM states:
  - IDLE: Busy=0.
  - RUN: Busy=1.
  - Done pulse is registered and valid for one cycle after leaving RUN.
- Start acceptance:
  - Start sampled high in IDLE at edge t0 latches Half_period (H, 0→1), Lead_b, Num_edges (N).
  - Latches D = min(Offset, H-1).
  - Forces A=B=0, Busy=1 at t0.
  - Input changes after t0 have no effect on the running burst.
- Start while Busy: ignored, with no effect on counters or outputs.
- Leading output toggles at edges t0+k·H, k=1..N.
- Lagging output toggles at edges t0+k·H+D, k=1..N.
- D=0: both outputs toggle on the same edge.
- Completion:
  - Completion edge is tc = t0+N·H+D, the edge of the last lag toggle.
  - At tc: Busy→0, Done=1 for exactly that one following cycle, FSM→IDLE.
- N=0: no toggles; tc = t0+1; Done pulses once.
- After completion, A and B hold their final levels (high if N odd) until the next accepted Start clears them.
- Start sampled in the same cycle Done is high (FSM already IDLE) is accepted.
- Stop sampled high in RUN: at that edge A=B=0, Busy=0, FSM→IDLE, no Done. Stop in IDLE is ignored.
- Stop and Start high together in IDLE: Start is accepted.
- Counters:
  - Period counter wraps 0..H-1.
  - Edge counters saturate at N; no toggle beyond N.
  - CNT_W-bit and NUM_W-bit arithmetic with no overflow for any legal inputs (max H=2^CNT_W-1).
- No combinational path from any input to A, B, Busy or Done.

Test Plan:
1. Reset, then Start at t0 with H=5, Offset=2, Lead_b=0, N=4:
   - A toggles at t0+5, 10, 15, 20.
   - B toggles at t0+7, 12, 17, 22.
   - Done is high for the cycle after t0+22; Busy is low from t0+22.
   - Final A=B=0.
2. Same setup with Lead_b=1, N=3:
   - B toggles at t0+5, 10, 15; A toggles at t0+7, 12, 17.
   - Final A=B=1; Done after t0+17.
3. Offset-clamp and edge cases:
   - H=4, Offset=9 (clamped to D=3), N=2: lead toggles at t0+4, 8; lag toggles at t0+7, 11.
   - H=3, Offset=0, N=2: A and B toggle together at t0+3, t0+6.
   - N=0: no toggles; Done at t0+1.
4. H=6, N=10, Stop at t0+20: A=B=0 at t0+20, Busy=0, no Done. A Start pulse at t0+8 causes no change to the running burst.
5. Assert Reset asynchronously mid-burst (between clock edges): A, B, Busy drop immediately, no Done. A subsequent Start runs a clean burst matching scenario 1 timing.
6. Back-to-back bursts: Start sampled in the cycle Done is high is accepted. Outputs clear to 0 at the new t0 and the new timing is exact. H=0 behaves as H=1 (toggle every cycle).
